// File: rtl/segment_7.sv
// segment_7: registered binary-to-seven-segment decoder for one display digit.
//
// Parameters:
//   ACTIVE_LOW  0 = lit segment driven 1 (common cathode); 1 = all outputs inverted
//   HEX_MODE    0 = codes 10-15 blank the digit; 1 = codes 10-15 show A b C d E F
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  synchronous active-high reset, drives outputs to all-off
//   num    in   4  digit code 0-15
//   dp_in  in   1  decimal-point request (1 = lit)
//   seg7   out  7  segment drive, bit order {g,f,e,d,c,b,a}
//   dp     out  1  decimal-point drive
module segment_7 #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_MODE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num,
  input  logic       dp_in,
  output logic [6:0] seg7,
  output logic       dp
);

  localparam int unsigned SEG_W = 7;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] GLYPH_0     = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1     = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2     = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3     = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4     = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5     = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6     = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7     = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8     = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9     = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_A     = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B     = 7'h7C;
  localparam logic [SEG_W-1:0] GLYPH_C     = 7'h39;
  localparam logic [SEG_W-1:0] GLYPH_D     = 7'h5E;
  localparam logic [SEG_W-1:0] GLYPH_E     = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_F     = 7'h71;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h00;

  // Polarity mask applied to both seg7 and dp at the register input
  localparam logic [SEG_W-1:0] POL_MASK = {SEG_W{ACTIVE_LOW}};
  localparam logic [SEG_W-1:0] SEG_OFF  = GLYPH_BLANK ^ POL_MASK;
  localparam logic             DP_OFF   = ACTIVE_LOW;

  logic [SEG_W-1:0] glyph_c;

  // Full decode of all 16 codes; hex codes either blank or show letters
  always_comb begin
    glyph_c = GLYPH_BLANK;
    unique case (num)
      4'd0:  glyph_c = GLYPH_0;
      4'd1:  glyph_c = GLYPH_1;
      4'd2:  glyph_c = GLYPH_2;
      4'd3:  glyph_c = GLYPH_3;
      4'd4:  glyph_c = GLYPH_4;
      4'd5:  glyph_c = GLYPH_5;
      4'd6:  glyph_c = GLYPH_6;
      4'd7:  glyph_c = GLYPH_7;
      4'd8:  glyph_c = GLYPH_8;
      4'd9:  glyph_c = GLYPH_9;
      4'd10: glyph_c = HEX_MODE ? GLYPH_A : GLYPH_BLANK;
      4'd11: glyph_c = HEX_MODE ? GLYPH_B : GLYPH_BLANK;
      4'd12: glyph_c = HEX_MODE ? GLYPH_C : GLYPH_BLANK;
      4'd13: glyph_c = HEX_MODE ? GLYPH_D : GLYPH_BLANK;
      4'd14: glyph_c = HEX_MODE ? GLYPH_E : GLYPH_BLANK;
      4'd15: glyph_c = HEX_MODE ? GLYPH_F : GLYPH_BLANK;
      default: glyph_c = GLYPH_BLANK;
    endcase
  end

  // Output register; reset wins over any input change at the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      seg7 <= SEG_OFF;
      dp   <= DP_OFF;
    end else begin
      seg7 <= glyph_c ^ POL_MASK;
      dp   <= dp_in ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_segment_7.sv
// tb_segment_7: table-driven check of segment_7 in all four parameter combinations,
// driven in parallel from shared inputs.
module tb_segment_7;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] num;
  logic       dp_in;

  logic [6:0] seg_dec, seg_hex, seg_dec_al, seg_hex_al;
  logic       dp_dec, dp_hex, dp_dec_al, dp_hex_al;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  segment_7 #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_dec (
    .clk(clk), .rst(rst), .num(num), .dp_in(dp_in), .seg7(seg_dec), .dp(dp_dec));
  segment_7 #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) u_hex (
    .clk(clk), .rst(rst), .num(num), .dp_in(dp_in), .seg7(seg_hex), .dp(dp_hex));
  segment_7 #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) u_dec_al (
    .clk(clk), .rst(rst), .num(num), .dp_in(dp_in), .seg7(seg_dec_al), .dp(dp_dec_al));
  segment_7 #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) u_hex_al (
    .clk(clk), .rst(rst), .num(num), .dp_in(dp_in), .seg7(seg_hex_al), .dp(dp_hex_al));

  typedef struct {
    logic       rst;
    logic [3:0] num;
    logic       dp_in;
    logic [6:0] exp_dec;  // active-high expectation, HEX_MODE=0
    logic [6:0] exp_hex;  // active-high expectation, HEX_MODE=1
    logic       exp_dp;   // active-high expectation
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {seg7,dp}=%h want %h", name, act, exp);
  endtask

  // Compare all four instances against one active-high expectation
  task automatic chk_all(input string tag, input logic [6:0] e_dec, input logic [6:0] e_hex,
                         input logic e_dp);
    chk({tag, " dec"},    {seg_dec,    dp_dec},    {e_dec, e_dp});
    chk({tag, " hex"},    {seg_hex,    dp_hex},    {e_hex, e_dp});
    chk({tag, " dec_al"}, {seg_dec_al, dp_dec_al}, {~e_dec, ~e_dp});
    chk({tag, " hex_al"}, {seg_hex_al, dp_hex_al}, {~e_hex, ~e_dp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] dec_tab[10];
  logic [6:0] hex_tab[6];
  logic       prev_dp;

  initial begin
    dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    hex_tab = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reset held 3 cycles with live inputs, then release
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b1, 4'd8, 1'b1, 7'h00, 7'h00, 1'b0});
    vecs.push_back('{1'b0, 4'd8, 1'b1, 7'h7F, 7'h7F, 1'b1});
    // Decimal sweep
    for (int i = 0; i < 10; i++)
      vecs.push_back('{1'b0, 4'(i), 1'b0, dec_tab[i], dec_tab[i], 1'b0});
    // Codes 10..15: blank in decimal mode, letters in hex mode
    for (int i = 0; i < 6; i++)
      vecs.push_back('{1'b0, 4'(10 + i), 1'b0, 7'h00, hex_tab[i], 1'b0});
    // Blanked digit keeps its decimal point
    vecs.push_back('{1'b0, 4'd10, 1'b1, 7'h00, 7'h77, 1'b1});
    vecs.push_back('{1'b0, 4'd3,  1'b0, 7'h4F, 7'h4F, 1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b0, 7'h3F, 7'h3F, 1'b0});
    // Reset priority over changing inputs
    vecs.push_back('{1'b1, 4'd15, 1'b1, 7'h00, 7'h00, 1'b0});
    vecs.push_back('{1'b1, 4'd5,  1'b0, 7'h00, 7'h00, 1'b0});
    vecs.push_back('{1'b0, 4'd2,  1'b1, 7'h5B, 7'h5B, 1'b1});

    rst = 1'b1; num = 4'd0; dp_in = 1'b0;
    foreach (vecs[i]) begin
      rst   = vecs[i].rst;
      num   = vecs[i].num;
      dp_in = vecs[i].dp_in;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_dec, vecs[i].exp_hex, vecs[i].exp_dp);
    end

    // num fixed at 5, dp_in toggled every cycle: outputs must lag exactly one edge
    rst = 1'b0; num = 4'd5; dp_in = 1'b0;
    step();
    chk_all("dp_seed", 7'h6D, 7'h6D, 1'b0);
    prev_dp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dp_in = ~prev_dp;
      #2;
      chk_all($sformatf("dp_hold%0d", i), 7'h6D, 7'h6D, prev_dp);
      step();
      chk_all($sformatf("dp_new%0d", i), 7'h6D, 7'h6D, ~prev_dp);
      prev_dp = ~prev_dp;
    end

    // Back-to-back code changes with no gap
    for (int i = 9; i >= 0; i--) begin
      num = 4'(i);
      step();
      chk_all($sformatf("b2b%0d", i), dec_tab[i], dec_tab[i], prev_dp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
